keypad_ssd_scan: RTL

KEYPAD_SSD_SCAN -- requirements
Module: keypad_ssd_scan

---
 rtl/ssd_pkg.sv | 17 +
 rtl/key_filter.sv | 38 +++
 rtl/keypad_ssd_scan.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types and hex-to-seven-segment encoding for the keypad display
package ssd_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] hex_t;

    // Active-high segments, bit 6 = a down to bit 0 = g
    localparam seg_t SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic seg_t hex_to_seg(input hex_t h);
        return SEG_TABLE[h];
    endfunction

endpackage

// File: rtl/key_filter.sv
// rtl/key_filter.sv - debounce of a synchronised level with a one-cycle rising-edge pulse
module key_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_pulse
);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             done;

    assign done = (cnt == CNT_W'(STABLE_CYCLES - 1));

    // cnt tracks how long din has disagreed with level; any agreement restarts the window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            if (din == level) begin
                cnt <= '0;
            end else if (done) begin
                cnt        <= '0;
                level      <= din;
                rise_pulse <= din;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_ssd_scan.sv
// rtl/keypad_ssd_scan.sv - keypad entry buffer with multiplexed SSD scan; SSD_LEAD_BLANK_EN blanks unused digits
module keypad_ssd_scan
    import ssd_pkg::*;
#(
    parameter int CLK_FREQ      = 125_000_000,
    parameter int NUM_DIGITS    = 2,
    parameter int REFRESH_HZ    = 1000,
    parameter int STABLE_CYCLES = CLK_FREQ / 100
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            key_valid,
    input  logic [3:0]                      key_code,
    input  logic                            clr,
    output logic [6:0]                      seg,
    output logic [NUM_DIGITS-1:0]           dig_sel,
    output logic                            key_event,
    output logic [$clog2(NUM_DIGITS+1)-1:0] entry_count
);
    localparam int CW         = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PERIOD_RAW = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
    localparam int PERIOD     = (PERIOD_RAW > 0) ? PERIOD_RAW : 1;
    localparam int SCAN_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic            valid_s1, valid_s2;
    hex_t            code_s1, code_s2;
    logic            key_level;
    logic            accept;
    hex_t            digits      [NUM_DIGITS];
    hex_t            digits_next [NUM_DIGITS];
    logic [CW-1:0]   count_next;
    logic [IDX_W-1:0] idx_next;
    seg_t            seg_next;

    // key_code rides the same two-flop chain so it stays aligned with key_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            code_s1  <= '0;
            code_s2  <= '0;
        end else begin
            valid_s1 <= key_valid;
            valid_s2 <= valid_s1;
            code_s1  <= key_code;
            code_s2  <= code_s1;
        end
    end

    key_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_key_filter (
        .clk        (clk),
        .rst        (rst),
        .din        (valid_s2),
        .level      (key_level),
        .rise_pulse (key_event)
    );

    assign accept = key_event & key_level;

    always_comb begin
        digits_next = digits;
        count_next  = entry_count;
        if (clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_next[i] = '0;
            end
            count_next = '0;
        end else if (accept) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                digits_next[i] = digits[i-1];
            end
            digits_next[0] = code_s2;
            if (entry_count != CW'(NUM_DIGITS)) begin
                count_next = entry_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= '0;
            end
            entry_count <= '0;
        end else begin
            digits      <= digits_next;
            entry_count <= count_next;
        end
    end

    generate
        if (NUM_DIGITS > 1) begin : g_scan
            logic [SCAN_W-1:0] scan_cnt;
            logic [IDX_W-1:0]  idx_q;
            logic              wrap;

            assign wrap = (scan_cnt == SCAN_W'(PERIOD - 1));

            always_comb begin
                idx_next = idx_q;
                if (wrap) begin
                    idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    scan_cnt <= '0;
                    idx_q    <= '0;
                    dig_sel  <= NUM_DIGITS'(1);
                end else if (wrap) begin
                    scan_cnt <= '0;
                    idx_q    <= idx_next;
                    dig_sel  <= NUM_DIGITS'(1) << idx_next;
                end else begin
                    scan_cnt <= scan_cnt + 1'b1;
                end
            end
        end else begin : g_single
            assign idx_next = '0;
            assign dig_sel  = 1'b1;
        end
    endgenerate

    // Encode from next-state digit and index so seg never lags dig_sel or the buffer
    always_comb begin
        seg_next = hex_to_seg(digits_next[0]);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(idx_next) == i) begin
                seg_next = hex_to_seg(digits_next[i]);
`ifdef SSD_LEAD_BLANK_EN
                if (i != 0 && i >= int'(count_next)) begin
                    seg_next = '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_TABLE[0];
        end else begin
            seg <= seg_next;
        end
    end

endmodule
